// File: rtl/ahb_slave_port_arbiter_pkg.sv
// ahb_arb_pkg: shared AHB-Lite types and helpers for the slave-port arbiter
// and its picker.
//   htrans_e    : AHB transfer type encoding.
//   hburst_e    : AHB burst type encoding.
//   arb_state_e : ownership state of one slave port.
//   burst_len() : beats in a fixed-length burst (0 = undefined-length INCR).
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWNED  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_e;

    // Wide enough to hold 15 (remaining beats of an INCR16/WRAP16).
    localparam int BCNT_W = 4;

    function automatic logic [4:0] burst_len(hburst_e b);
        case (b)
            HB_SINGLE:           return 5'd1;
            HB_WRAP4, HB_INCR4:  return 5'd4;
            HB_WRAP8, HB_INCR8:  return 5'd8;
            HB_WRAP16, HB_INCR16: return 5'd16;
            default:             return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_slave_port_arbiter_if.sv
// ahb_slave_port_arbiter_if: per-slave-port arbitration bundle.
//   i_req/i_htrans/i_hburst/i_hmastlock : per-master address-phase controls
//   i_hreadyout                         : slave HREADYOUT
//   o_grant/o_grant_idx                 : registered address-phase grant
//   o_dp_valid/o_dp_owner               : registered data-phase tracking
//   o_mhready/o_shready/o_hselx         : combinational ready/select routing
// Modports: master = side driving the requests (layers + slave),
//           slave  = the arbiter.
interface ahb_slave_port_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int MIDX_W      = $clog2(NUM_MASTERS)
);
    logic [NUM_MASTERS-1:0]      i_req;
    logic [NUM_MASTERS-1:0][1:0] i_htrans;
    logic [NUM_MASTERS-1:0][2:0] i_hburst;
    logic [NUM_MASTERS-1:0]      i_hmastlock;
    logic                        i_hreadyout;
    logic [NUM_MASTERS-1:0]      o_grant;
    logic [MIDX_W-1:0]           o_grant_idx;
    logic                        o_dp_valid;
    logic [MIDX_W-1:0]           o_dp_owner;
    logic [NUM_MASTERS-1:0]      o_mhready;
    logic                        o_shready;
    logic                        o_hselx;

    modport master (
        output i_req, i_htrans, i_hburst, i_hmastlock, i_hreadyout,
        input  o_grant, o_grant_idx, o_dp_valid, o_dp_owner,
               o_mhready, o_shready, o_hselx
    );

    modport slave (
        input  i_req, i_htrans, i_hburst, i_hmastlock, i_hreadyout,
        output o_grant, o_grant_idx, o_dp_valid, o_dp_owner,
               o_mhready, o_shready, o_hselx
    );
endinterface

// File: rtl/ahb_slave_port_arbiter_picker.sv
// rr_arb_picker: combinational winner selection.
//   req    : request vector
//   ptr    : round-robin search start (ignored in fixed-priority mode)
//   onehot : one-hot winner
//   idx    : encoded winner
//   found  : at least one request present
// ARB_MODE 0 searches ptr, ptr+1, ... wrapping at NUM_MASTERS-1;
// ARB_MODE 1 always picks the lowest requesting index.
module rr_arb_picker #(
    parameter int NUM_MASTERS = 4,
    parameter int ARB_MODE    = 0,
    parameter int MIDX_W      = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MIDX_W-1:0]      ptr,
    output logic [NUM_MASTERS-1:0] onehot,
    output logic [MIDX_W-1:0]      idx,
    output logic                   found
);
    int cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (ARB_MODE == 1) begin
                cand = i;
            end else begin
                cand = (int'(ptr) + i) % NUM_MASTERS;
            end
            if (!found && req[cand]) begin
                found        = 1'b1;
                idx          = MIDX_W'(cand);
                onehot[cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ahb_slave_port_arbiter.sv
// ahb_slave_port_arbiter: per-slave address-phase arbiter for the multilayer
// AHB-Lite interconnect.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : requests/HTRANS/HBURST/HMASTLOCK in, grant, data-phase
//                  owner and HREADY/HSEL routing out.
// Ownership is held across fixed-length bursts and locked sequences; all
// state advances only on cycles where the slave is ready.
module ahb_slave_port_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ARB_MODE    = 0,
    parameter int MIDX_W      = $clog2(NUM_MASTERS)
) (
    input logic                    i_clk,
    input logic                    i_rst,
    ahb_slave_port_arbiter_if.slave bus
);
    arb_state_e             state;
    logic [NUM_MASTERS-1:0] grant;
    logic [MIDX_W-1:0]      grant_idx;
    logic [MIDX_W-1:0]      rr_ptr;
    logic                   dp_valid;
    logic [MIDX_W-1:0]      dp_owner;
    logic [BCNT_W-1:0]      beat_cnt;
    logic                   undef_len;

    logic [NUM_MASTERS-1:0] win_oh;
    logic [MIDX_W-1:0]      win_idx;
    logic                   win_found;
    logic [MIDX_W-1:0]      next_ptr;

    logic                   owner_req;
    logic                   owner_lock;
    htrans_e                owner_trans;
    hburst_e                owner_burst;
    logic                   beat_ok;
    logic [4:0]             len;
    logic [BCNT_W-1:0]      cnt_next;
    logic                   undef_next;
    logic                   burst_done;
    logic                   arb_point;
    logic                   stay_locked;

    rr_arb_picker #(
        .NUM_MASTERS(NUM_MASTERS),
        .ARB_MODE   (ARB_MODE),
        .MIDX_W     (MIDX_W)
    ) u_picker (
        .req   (bus.i_req),
        .ptr   (rr_ptr),
        .onehot(win_oh),
        .idx   (win_idx),
        .found (win_found)
    );

    assign owner_req   = bus.i_req[grant_idx];
    assign owner_lock  = bus.i_hmastlock[grant_idx];
    assign owner_trans = htrans_e'(bus.i_htrans[grant_idx]);
    assign owner_burst = hburst_e'(bus.i_hburst[grant_idx]);

    // A real beat from the current owner; it is accepted when HREADYOUT=1.
    assign beat_ok = (|grant) && owner_req &&
                     (owner_trans == HT_NONSEQ || owner_trans == HT_SEQ);

    // The pointer holds the next search start, i.e. last owner + 1.
    assign next_ptr = (win_idx == MIDX_W'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;

    always_comb begin
        cnt_next   = beat_cnt;
        undef_next = undef_len;
        burst_done = 1'b0;
        len        = burst_len(owner_burst);
        if (beat_ok) begin
            if (owner_trans == HT_NONSEQ) begin
                undef_next = (len == 5'd0);
                cnt_next   = (len == 5'd0) ? '0 : BCNT_W'(len - 5'd1);
                burst_done = (len == 5'd1);
            end else if (!undef_len && beat_cnt != '0) begin
                // BUSY never reaches here, so it does not consume a beat.
                cnt_next   = beat_cnt - 1'b1;
                burst_done = (beat_cnt == BCNT_W'(1));
            end
        end
    end

    assign arb_point   = !owner_req || owner_trans == HT_IDLE || burst_done;
    // Lock is taken only on an accepted beat, but kept on any ready cycle
    // while the owner still asserts HMASTLOCK.
    assign stay_locked = owner_lock &&
                         (state == ST_LOCKED || (state == ST_OWNED && beat_ok));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            grant     <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
            dp_valid  <= 1'b0;
            dp_owner  <= '0;
            beat_cnt  <= '0;
            undef_len <= 1'b0;
        end else if (bus.i_hreadyout) begin
            dp_valid  <= beat_ok;
            if (beat_ok) begin
                dp_owner <= grant_idx;
            end
            beat_cnt  <= cnt_next;
            undef_len <= undef_next;
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        state     <= ST_OWNED;
                        grant     <= win_oh;
                        grant_idx <= win_idx;
                        rr_ptr    <= next_ptr;
                    end
                end
                default: begin
                    if (stay_locked) begin
                        state <= ST_LOCKED;
                    end else begin
                        state <= ST_OWNED;
                        if (arb_point) begin
                            if (!win_found) begin
                                state     <= ST_IDLE;
                                grant     <= '0;
                                grant_idx <= '0;
                            end else if (win_idx != grant_idx) begin
                                grant     <= win_oh;
                                grant_idx <= win_idx;
                                rr_ptr    <= next_ptr;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.o_grant     = grant;
    assign bus.o_grant_idx = grant_idx;
    assign bus.o_dp_valid  = dp_valid;
    assign bus.o_dp_owner  = dp_owner;
    assign bus.o_hselx     = |(grant & bus.i_req);
    assign bus.o_shready   = dp_valid ? bus.i_hreadyout : 1'b1;

    // Data-phase owner and address-phase grantee follow the slave; other
    // requesters are stalled; idle masters see a ready bus.
    always_comb begin
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if ((dp_valid && dp_owner == MIDX_W'(m)) || grant[m]) begin
                bus.o_mhready[m] = bus.i_hreadyout;
            end else if (bus.i_req[m]) begin
                bus.o_mhready[m] = 1'b0;
            end else begin
                bus.o_mhready[m] = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ahb_slave_port_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance,
// each scenario in its own task with inline comparisons.
module tb_ahb_slave_port_arbiter;
    import ahb_arb_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ahb_slave_port_arbiter_if #(.NUM_MASTERS(4)) rr_bus ();
    ahb_slave_port_arbiter_if #(.NUM_MASTERS(4)) fp_bus ();

    ahb_slave_port_arbiter #(.NUM_MASTERS(4), .ARB_MODE(0)) u_rr (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (rr_bus.slave)
    );

    ahb_slave_port_arbiter #(.NUM_MASTERS(4), .ARB_MODE(1)) u_fp (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (fp_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rr(input int m, input logic req, input htrans_e tr,
                          input hburst_e hb, input logic lk);
        rr_bus.i_req[m]       = req;
        rr_bus.i_htrans[m]    = tr;
        rr_bus.i_hburst[m]    = hb;
        rr_bus.i_hmastlock[m] = lk;
    endtask

    task automatic set_fp(input int m, input logic req, input htrans_e tr,
                          input hburst_e hb, input logic lk);
        fp_bus.i_req[m]       = req;
        fp_bus.i_htrans[m]    = tr;
        fp_bus.i_hburst[m]    = hb;
        fp_bus.i_hmastlock[m] = lk;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int m = 0; m < 4; m++) begin
            set_rr(m, 1'b0, HT_IDLE, HB_SINGLE, 1'b0);
            set_fp(m, 1'b0, HT_IDLE, HB_SINGLE, 1'b0);
        end
        rr_bus.i_hreadyout = 1'b1;
        fp_bus.i_hreadyout = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rr_bus.o_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", rr_bus.o_grant); end
        checks++; if (rr_bus.o_grant_idx !== 2'd0) begin errors++; $display("FAIL reset_grant_idx got %0d exp 0", rr_bus.o_grant_idx); end
        checks++; if (rr_bus.o_dp_valid !== 1'b0) begin errors++; $display("FAIL reset_dp_valid got %b exp 0", rr_bus.o_dp_valid); end
        checks++; if (rr_bus.o_dp_owner !== 2'd0) begin errors++; $display("FAIL reset_dp_owner got %0d exp 0", rr_bus.o_dp_owner); end
        checks++; if (rr_bus.o_hselx !== 1'b0) begin errors++; $display("FAIL reset_hselx got %b exp 0", rr_bus.o_hselx); end
        checks++; if (rr_bus.o_shready !== 1'b1) begin errors++; $display("FAIL reset_shready got %b exp 1", rr_bus.o_shready); end
        checks++; if (rr_bus.o_mhready !== 4'b1111) begin errors++; $display("FAIL reset_mhready got %b exp 1111", rr_bus.o_mhready); end
    endtask

    task automatic test_rr_fairness();
        logic [3:0] exp_g [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] exp_m [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
        logic [1:0] exp_o [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        do_reset();
        for (int m = 0; m < 4; m++) set_rr(m, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b0);
        step();
        checks++; if (rr_bus.o_grant !== 4'b0001) begin errors++; $display("FAIL rr_first_grant got %b exp 0001", rr_bus.o_grant); end
        checks++; if (rr_bus.o_mhready !== 4'b0001) begin errors++; $display("FAIL rr_first_mhready got %b exp 0001", rr_bus.o_mhready); end
        checks++; if (rr_bus.o_dp_valid !== 1'b0) begin errors++; $display("FAIL rr_first_dp_valid got %b exp 0", rr_bus.o_dp_valid); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (rr_bus.o_grant !== exp_g[i]) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", i, rr_bus.o_grant, exp_g[i]); end
            checks++; if (rr_bus.o_dp_owner !== exp_o[i]) begin errors++; $display("FAIL rr_dp_owner[%0d] got %0d exp %0d", i, rr_bus.o_dp_owner, exp_o[i]); end
            checks++; if (rr_bus.o_mhready !== exp_m[i]) begin errors++; $display("FAIL rr_mhready[%0d] got %b exp %b", i, rr_bus.o_mhready, exp_m[i]); end
        end
        checks++; if (rr_bus.o_hselx !== 1'b1) begin errors++; $display("FAIL rr_hselx got %b exp 1", rr_bus.o_hselx); end
        for (int m = 0; m < 4; m++) set_rr(m, 1'b0, HT_IDLE, HB_SINGLE, 1'b0);
        step();
        checks++; if (rr_bus.o_grant !== 4'b0000) begin errors++; $display("FAIL rr_release_grant got %b exp 0000", rr_bus.o_grant); end
        checks++; if (rr_bus.o_dp_valid !== 1'b0) begin errors++; $display("FAIL rr_release_dp_valid got %b exp 0", rr_bus.o_dp_valid); end
    endtask

    task automatic test_burst_hold();
        do_reset();
        set_rr(1, 1'b1, HT_NONSEQ, HB_INCR4, 1'b0);
        step();
        checks++; if (rr_bus.o_grant !== 4'b0010) begin errors++; $display("FAIL burst_grant_m1 got %b exp 0010", rr_bus.o_grant); end
        set_rr(0, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b0);
        step();  // beat 1 (NONSEQ)
        checks++; if (rr_bus.o_grant !== 4'b0010) begin errors++; $display("FAIL burst_hold_b1 got %b exp 0010", rr_bus.o_grant); end
        set_rr(1, 1'b1, HT_SEQ, HB_INCR4, 1'b0);
        step();  // beat 2
        checks++; if (rr_bus.o_grant !== 4'b0010) begin errors++; $display("FAIL burst_hold_b2 got %b exp 0010", rr_bus.o_grant); end
        set_rr(1, 1'b1, HT_BUSY, HB_INCR4, 1'b0);
        step();  // BUSY
        checks++; if (rr_bus.o_grant !== 4'b0010) begin errors++; $display("FAIL burst_hold_busy got %b exp 0010", rr_bus.o_grant); end
        checks++; if (rr_bus.o_dp_valid !== 1'b0) begin errors++; $display("FAIL burst_busy_dp_valid got %b exp 0", rr_bus.o_dp_valid); end
        checks++; if (rr_bus.o_mhready !== 4'b1110) begin errors++; $display("FAIL burst_busy_mhready got %b exp 1110", rr_bus.o_mhready); end
        set_rr(1, 1'b1, HT_SEQ, HB_INCR4, 1'b0);
        step();  // beat 3
        checks++; if (rr_bus.o_grant !== 4'b0010) begin errors++; $display("FAIL burst_hold_b3 got %b exp 0010", rr_bus.o_grant); end
        step();  // beat 4: handover
        checks++; if (rr_bus.o_grant !== 4'b0001) begin errors++; $display("FAIL burst_handover got %b exp 0001", rr_bus.o_grant); end
        checks++; if (rr_bus.o_dp_valid !== 1'b1) begin errors++; $display("FAIL burst_last_dp_valid got %b exp 1", rr_bus.o_dp_valid); end
        checks++; if (rr_bus.o_dp_owner !== 2'd1) begin errors++; $display("FAIL burst_last_dp_owner got %0d exp 1", rr_bus.o_dp_owner); end
    endtask

    task automatic test_lock();
        do_reset();
        set_rr(2, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b1);
        step();
        checks++; if (rr_bus.o_grant !== 4'b0100) begin errors++; $display("FAIL lock_grant_m2 got %b exp 0100", rr_bus.o_grant); end
        set_rr(0, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b0);
        set_rr(1, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b0);
        step();  // first locked SINGLE
        checks++; if (rr_bus.o_grant !== 4'b0100) begin errors++; $display("FAIL lock_hold_1 got %b exp 0100", rr_bus.o_grant); end
        step();  // second locked SINGLE
        checks++; if (rr_bus.o_grant !== 4'b0100) begin errors++; $display("FAIL lock_hold_2 got %b exp 0100", rr_bus.o_grant); end
        rr_bus.i_hreadyout = 1'b0;
        set_rr(2, 1'b1, HT_IDLE, HB_SINGLE, 1'b0);
        step();  // unlock not sampled during wait state
        checks++; if (rr_bus.o_grant !== 4'b0100) begin errors++; $display("FAIL lock_hold_wait got %b exp 0100", rr_bus.o_grant); end
        checks++; if (rr_bus.o_mhready !== 4'b1000) begin errors++; $display("FAIL lock_wait_mhready got %b exp 1000", rr_bus.o_mhready); end
        rr_bus.i_hreadyout = 1'b1;
        step();  // unlock sampled: handover
        checks++; if (rr_bus.o_grant !== 4'b0001) begin errors++; $display("FAIL lock_release got %b exp 0001", rr_bus.o_grant); end
    endtask

    task automatic test_wait_states();
        do_reset();
        set_rr(3, 1'b1, HT_NONSEQ, HB_INCR8, 1'b0);
        step();
        checks++; if (rr_bus.o_grant !== 4'b1000) begin errors++; $display("FAIL wait_grant_m3 got %b exp 1000", rr_bus.o_grant); end
        set_rr(0, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b0);
        step();  // beat 1
        set_rr(3, 1'b1, HT_SEQ, HB_INCR8, 1'b0);
        step();  // beat 2
        step();  // beat 3
        rr_bus.i_hreadyout = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (rr_bus.o_grant !== 4'b1000) begin errors++; $display("FAIL wait_grant[%0d] got %b exp 1000", i, rr_bus.o_grant); end
            checks++; if (rr_bus.o_dp_owner !== 2'd3) begin errors++; $display("FAIL wait_dp_owner[%0d] got %0d exp 3", i, rr_bus.o_dp_owner); end
            checks++; if (rr_bus.o_mhready !== 4'b0110) begin errors++; $display("FAIL wait_mhready[%0d] got %b exp 0110", i, rr_bus.o_mhready); end
            checks++; if (rr_bus.o_shready !== 1'b0) begin errors++; $display("FAIL wait_shready[%0d] got %b exp 0", i, rr_bus.o_shready); end
        end
        rr_bus.i_hreadyout = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();  // beats 4..7
            checks++; if (rr_bus.o_grant !== 4'b1000) begin errors++; $display("FAIL wait_resume[%0d] got %b exp 1000", i, rr_bus.o_grant); end
        end
        step();  // beat 8
        checks++; if (rr_bus.o_grant !== 4'b0001) begin errors++; $display("FAIL wait_handover got %b exp 0001", rr_bus.o_grant); end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        set_fp(3, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b0);
        step();
        checks++; if (fp_bus.o_grant !== 4'b1000) begin errors++; $display("FAIL fp_grant_m3 got %b exp 1000", fp_bus.o_grant); end
        set_fp(1, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b0);
        set_fp(2, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b0);
        step();
        checks++; if (fp_bus.o_grant !== 4'b0010) begin errors++; $display("FAIL fp_grant_m1 got %b exp 0010", fp_bus.o_grant); end
        checks++; if (fp_bus.o_grant_idx !== 2'd1) begin errors++; $display("FAIL fp_grant_idx got %0d exp 1", fp_bus.o_grant_idx); end
        step();
        checks++; if (fp_bus.o_grant !== 4'b0010) begin errors++; $display("FAIL fp_keep_m1 got %b exp 0010", fp_bus.o_grant); end
        set_fp(1, 1'b0, HT_IDLE, HB_SINGLE, 1'b0);
        step();
        checks++; if (fp_bus.o_grant !== 4'b0100) begin errors++; $display("FAIL fp_grant_m2 got %b exp 0100", fp_bus.o_grant); end
        set_fp(2, 1'b0, HT_IDLE, HB_SINGLE, 1'b0);
        step();
        checks++; if (fp_bus.o_grant !== 4'b1000) begin errors++; $display("FAIL fp_regain_m3 got %b exp 1000", fp_bus.o_grant); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_rr(0, 1'b1, HT_NONSEQ, HB_INCR16, 1'b0);
        step();
        set_rr(1, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b0);
        step();  // beat 1
        set_rr(0, 1'b1, HT_SEQ, HB_INCR16, 1'b0);
        step();  // beat 2
        step();  // beat 3
        step();  // beat 4
        checks++; if (rr_bus.o_grant !== 4'b0001) begin errors++; $display("FAIL rstb_hold got %b exp 0001", rr_bus.o_grant); end
        rst = 1'b1;
        step();  // reset during beat 5
        checks++; if (rr_bus.o_grant !== 4'b0000) begin errors++; $display("FAIL rstb_grant got %b exp 0000", rr_bus.o_grant); end
        checks++; if (rr_bus.o_dp_valid !== 1'b0) begin errors++; $display("FAIL rstb_dp_valid got %b exp 0", rr_bus.o_dp_valid); end
        checks++; if (rr_bus.o_hselx !== 1'b0) begin errors++; $display("FAIL rstb_hselx got %b exp 0", rr_bus.o_hselx); end
        checks++; if (rr_bus.o_mhready !== 4'b1100) begin errors++; $display("FAIL rstb_mhready_req got %b exp 1100", rr_bus.o_mhready); end
        for (int m = 0; m < 4; m++) set_rr(m, 1'b0, HT_IDLE, HB_SINGLE, 1'b0);
        #1;
        checks++; if (rr_bus.o_mhready !== 4'b1111) begin errors++; $display("FAIL rstb_mhready_idle got %b exp 1111", rr_bus.o_mhready); end
        rst = 1'b0;
        set_rr(0, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b0);
        set_rr(1, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b0);
        step();  // fresh arbitration from pointer 0
        checks++; if (rr_bus.o_grant !== 4'b0001) begin errors++; $display("FAIL rstb_regrant got %b exp 0001", rr_bus.o_grant); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        test_reset();
        test_rr_fairness();
        test_burst_hold();
        test_lock();
        test_wait_states();
        test_fixed_priority();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
